// File: rtl/rom_fetch.sv
// ----------------------------------------------------------------------------
// rom_fetch
//
// Instruction-fetch sequencer in front of a 1K x 32 synchronous-read ROM.
// Drives the ROM address/enable, absorbs the ROM's one-cycle read latency and
// hands {inst_pc, inst} to decode over a valid/ready handshake. A redirect
// loads a new fetch address, drops the in-flight read and flushes the
// 2-entry output buffer.
//
// Ports
//   clka         in   1   clock (rising edge), shared with the ROM
//   resetn       in   1   synchronous active-low reset
//   rom_addr     out  10  ROM word address (addra)
//   rom_en       out  1   ROM read enable (ena)
//   rom_data     in   32  ROM read data (douta), valid the cycle after issue
//   redirect     in   1   jump/branch: refetch from redirect_pc, flush
//   redirect_pc  in   10  redirect target word address
//   inst_valid   out  1   inst/inst_pc hold a valid word
//   inst_ready   in   1   decode takes the word this cycle
//   inst         out  32  instruction word
//   inst_pc      out  10  word address of inst
//
// Occupancy model: words buffered (r_count) plus the read in flight (r_pend)
// never exceed 2. A new read is issued only when that total, after this
// cycle's pop, is below 2, so a response always has a slot to land in.
//
//   state            | meaning
//   r_pend=0, cnt=0  | idle / just reset or flushed, nothing buffered
//   r_pend=1         | read outstanding, data arrives on rom_data this cycle
//   cnt=1..2         | words waiting for decode, head drives the outputs
// ----------------------------------------------------------------------------
module rom_fetch #(
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic        clka,
    input  logic        resetn,
    output logic [9:0]  rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [9:0]  inst_pc
);

    logic [9:0]  r_pc;
    logic        r_pend;
    logic [9:0]  r_pend_pc;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_mem_inst [0:1];
    logic [9:0]  r_mem_pc   [0:1];

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;

    assign w_pop  = inst_valid & inst_ready;
    // Response is dropped when a redirect lands on the same edge.
    assign w_push = r_pend & ~redirect;
    // Occupancy left after this cycle's pop; pop <= count so this never underflows.
    assign w_occ  = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};

    assign rom_addr = redirect ? redirect_pc : r_pc;
    assign rom_en   = resetn & (redirect | (w_occ < 3'd2));

    // Outputs are forced quiet for the whole reset cycle, not only after the
    // reset edge, so decode never sees a word while resetn is low.
    assign inst_valid = resetn & (r_count != 2'd0);
    assign inst       = resetn ? r_mem_inst[r_rd_ptr] : 32'd0;
    assign inst_pc    = resetn ? r_mem_pc[r_rd_ptr]   : 10'd0;

    always_ff @(posedge clka) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= 10'd0;
            r_count   <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem_inst[i] <= 32'd0;
                r_mem_pc[i]   <= 10'd0;
            end
        end else begin
            r_pend <= rom_en;
            if (rom_en) begin
                r_pend_pc <= rom_addr;
                r_pc      <= rom_addr + 10'd1;
            end

            if (redirect) begin
                // The handshake of this cycle already completed; the rest is flushed.
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem_inst[r_wr_ptr] <= rom_data;
                    r_mem_pc[r_wr_ptr]   <= r_pend_pc;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
